// File: rtl/dms_cp_prog.sv
// dms_cp_prog: programmable-current charge pump for the DMS CDR loop.
// Binary-weighted current DAC (i_active * I_LSB_NA) with a clocked soft-start ramp,
// per-direction compliance gating and an optional stuck-pulse limiter.
// Build option: define DMS_CP_PULSE_LIMIT_EN to compile in the stuck-pulse limiter;
// without it up_blk/dn_blk are constant 0 and pulse_err is tied to 0.
// The cp_out electrical node is carried as fixed-point quantities: node voltage in mV
// (cp_out_v) and load resistance in ohm (cp_out_r) come in, source current magnitudes
// (cp_up_i, cp_dn_i) and the net current into the node (cp_out_i) go out, all in nA.
module dms_cp_prog #(
  parameter int unsigned V_VDD_MV    = 3000,   // up-source supply, 3.0 V
  parameter int unsigned N_BITS      = 4,
  parameter int unsigned I_LSB_NA    = 10000,  // 1e-5 A per code LSB
  parameter int unsigned RAMP_DIV    = 8,      // >= 1
  parameter int unsigned MAX_PULSE   = 16,     // >= 2
  parameter int unsigned V_MARGIN_MV = 100,    // 0.1 V headroom to either rail
  parameter int unsigned R_MAX_OHM   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               down,
  input  logic [N_BITS-1:0]  i_code,
  input  logic [15:0]        cp_out_v,
  input  logic [31:0]        cp_out_r,
  output logic [31:0]        cp_up_i,
  output logic [31:0]        cp_dn_i,
  output logic signed [31:0] cp_out_i,
  output logic [N_BITS-1:0]  i_active,
  output logic               ramp_done,
  output logic               up_sat,
  output logic               dn_sat,
  output logic               pulse_err
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [31:0] UP_V_LIM = 32'(V_VDD_MV - V_MARGIN_MV);
  localparam logic [31:0] DN_V_LIM = 32'(V_MARGIN_MV);
  localparam logic [31:0] R_LIM    = 32'(R_MAX_OHM);

  typedef enum logic [1:0] {StIdle, StRamp, StLocked} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [N_BITS-1:0] step_code;
  logic              up_ok;
  logic              dn_ok;
  logic              up_blk;
  logic              dn_blk;
  logic [31:0]       mag;
  logic [31:0]       v_ext;

  // Compliance: each source needs headroom to its rail and a bounded load
  always_comb begin
    v_ext = {16'd0, cp_out_v};
    up_ok = (v_ext <= UP_V_LIM) && (cp_out_r <= R_LIM);
    dn_ok = (v_ext >= DN_V_LIM) && (cp_out_r <= R_LIM);
  end

  // Source currents follow up/down combinationally; everything is off during reset
  always_comb begin
    mag     = 32'(i_active) * I_LSB_NA;
    cp_up_i = (up && up_ok && !up_blk && !rst) ? mag : 32'd0;
    cp_dn_i = (down && dn_ok && !dn_blk && !rst) ? mag : 32'd0;
  end

  assign cp_out_i = $signed(cp_up_i) - $signed(cp_dn_i);

  // One LSB toward the target; moving toward an in-range target can never wrap
  always_comb begin
    step_code = i_active;
    if (i_code > i_active) begin
      step_code = i_active + 1'b1;
    end else if (i_code < i_active) begin
      step_code = i_active - 1'b1;
    end
  end

  // Soft-start FSM: ramp i_active toward i_code one LSB per RAMP_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      i_active  <= '0;
      ramp_done <= 1'b0;
    end else if (!en) begin
      state_q   <= StIdle;
      div_q     <= '0;
      i_active  <= '0;
      ramp_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          div_q <= '0;
          if (i_code == '0) begin
            state_q   <= StLocked;
            ramp_done <= 1'b1;
          end else begin
            state_q <= StRamp;
          end
        end
        StRamp: begin
          // Target is re-read at every step, so i_code changes apply without restarting the divider
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            i_active <= step_code;
            if (step_code == i_code) begin
              state_q   <= StLocked;
              ramp_done <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StLocked: begin
          if (i_code != i_active) begin
            state_q   <= StRamp;
            div_q     <= '0;
            ramp_done <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          div_q     <= '0;
          i_active  <= '0;
          ramp_done <= 1'b0;
        end
      endcase
    end
  end

  // Saturation flags: request present but source gated by compliance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sat <= 1'b0;
      dn_sat <= 1'b0;
    end else begin
      up_sat <= up & ~up_ok;
      dn_sat <= down & ~dn_ok;
    end
  end

`ifdef DMS_CP_PULSE_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_PULSE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PULSE);

  logic [CNT_W-1:0] up_cnt_q;
  logic [CNT_W-1:0] dn_cnt_q;

  // Stuck-pulse limiter: block a direction once it has been high MAX_PULSE samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt_q  <= '0;
      dn_cnt_q  <= '0;
      up_blk    <= 1'b0;
      dn_blk    <= 1'b0;
      pulse_err <= 1'b0;
    end else if (!en) begin
      up_cnt_q  <= '0;
      dn_cnt_q  <= '0;
      up_blk    <= 1'b0;
      dn_blk    <= 1'b0;
      pulse_err <= 1'b0;
    end else begin
      if (up) begin
        if (up_cnt_q != CNT_MAX) up_cnt_q <= up_cnt_q + 1'b1;
        if (up_cnt_q == CNT_MAX) up_blk <= 1'b1;
      end else begin
        up_cnt_q <= '0;
        up_blk   <= 1'b0;
      end
      if (down) begin
        if (dn_cnt_q != CNT_MAX) dn_cnt_q <= dn_cnt_q + 1'b1;
        if (dn_cnt_q == CNT_MAX) dn_blk <= 1'b1;
      end else begin
        dn_cnt_q <= '0;
        dn_blk   <= 1'b0;
      end
      // Sticky until reset or disable
      if ((up && (up_cnt_q == CNT_MAX)) || (down && (dn_cnt_q == CNT_MAX))) begin
        pulse_err <= 1'b1;
      end
    end
  end
`else
  assign up_blk    = 1'b0;
  assign dn_blk    = 1'b0;
  assign pulse_err = 1'b0;
`endif

endmodule
